// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card single-block read path (SPI mode).
package sd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEND_CMD,
        WAIT_R1,
        WAIT_TOKEN,
        READ_DATA,
        READ_CRC,
        TRAIL,
        FAIL,
        DONE
    } sdStateT;

    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] DUMMY_BYTE  = 8'hFF;
    localparam int         BLOCK_LEN   = 512;

    // Byte idx of the 6-byte CMD17 frame; the CRC slot is a dummy byte in SPI mode.
    function automatic logic [7:0] cmdByte(input logic [31:0] sector, input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD17;
            3'd1:    return sector[31:24];
            3'd2:    return sector[23:16];
            3'd3:    return sector[15:8];
            3'd4:    return sector[7:0];
            default: return DUMMY_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// One full-duplex SPI byte (mode 0, MSB first) with SCLK generation and start/done handshake.
module sd_spi_byte #(
    parameter int CLK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] txByte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rxByte,
    output logic       rxStrobe,
    output logic       done
);

    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divCnt;
    logic [3:0]    bitCnt;
    logic [7:0]    txShift;
    logic [7:0]    rxShift;
    logic          active;

    assign mosi = txShift[7];

    // Rising half samples MISO; falling half advances MOSI, refilling with ones so DI idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt   <= '0;
            bitCnt   <= '0;
            txShift  <= 8'hFF;
            rxShift  <= '0;
            rxByte   <= '0;
            active   <= 1'b0;
            sclk     <= 1'b0;
            rxStrobe <= 1'b0;
            done     <= 1'b0;
        end else begin
            rxStrobe <= 1'b0;
            done     <= 1'b0;
            if (!active) begin
                divCnt <= '0;
                if (start) begin
                    active  <= 1'b1;
                    txShift <= txByte;
                    bitCnt  <= '0;
                end
            end else if (divCnt == DIV_LAST) begin
                divCnt <= '0;
                sclk   <= ~sclk;
                if (!sclk) begin
                    rxShift <= {rxShift[6:0], miso};
                    bitCnt  <= bitCnt + 4'd1;
                    if (bitCnt == 4'd7) begin
                        rxByte   <= {rxShift[6:0], miso};
                        rxStrobe <= 1'b1;
                    end
                end else begin
                    txShift <= {txShift[6:0], 1'b1};
                    if (bitCnt == 4'd8) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end
                end
            end else begin
                divCnt <= divCnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/sd_block_read.sv
// CMD17 single 512-byte block read from an initialised SDHC card over SPI.
module sd_block_read
    import sd_pkg::*;
#(
    parameter int CLK_DIV       = 100,
    parameter int R1_TIMEOUT    = 8,
    parameter int TOKEN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        initDone,
    input  logic        isStart,
    input  logic [31:0] sector,
    input  logic        DO,
    output logic        SCLK,
    output logic        DI,
    output logic        CS,
    output logic [7:0]  data,
    output logic        dataValid,
    output logic        isBusy,
    output logic        isFinish,
    output logic        error
);

    localparam logic [15:0] R1_LAST    = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT - 1);
    localparam logic [8:0]  LAST_BYTE  = 9'(BLOCK_LEN - 1);

    sdStateT     state;
    sdStateT     stateNext;
    logic [31:0] sectorReg;
    logic [8:0]  byteCnt;
    logic [15:0] pollCnt;
    logic        pending;
    logic        accept;
    logic        byteState;
    logic        byteStart;
    logic        byteDone;
    logic        rxStrobe;
    logic [7:0]  txByte;
    logic [7:0]  rxByte;

    assign accept    = (state == IDLE) && initDone && isStart;
    assign byteState = state inside {SEND_CMD, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC, TRAIL, FAIL};
    assign byteStart = byteState && !pending;
    assign txByte    = (state == SEND_CMD) ? cmdByte(sectorReg, byteCnt[2:0]) : DUMMY_BYTE;
    assign CS        = !(state inside {SEND_CMD, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC});

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) spiByte (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (byteStart),
        .txByte   (txByte),
        .miso     (DO),
        .sclk     (SCLK),
        .mosi     (DI),
        .rxByte   (rxByte),
        .rxStrobe (rxStrobe),
        .done     (byteDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Transitions are decided once per completed byte, using the byte just received.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (accept) stateNext = SEND_CMD;
            SEND_CMD:   if (byteDone && byteCnt == 9'd5) stateNext = WAIT_R1;
            WAIT_R1:
                if (byteDone) begin
                    if (rxByte == 8'h00)                                 stateNext = WAIT_TOKEN;
                    else if (rxByte != DUMMY_BYTE || pollCnt == R1_LAST) stateNext = FAIL;
                end
            WAIT_TOKEN:
                if (byteDone) begin
                    if (rxByte == START_TOKEN)                              stateNext = READ_DATA;
                    else if (rxByte != DUMMY_BYTE || pollCnt == TOKEN_LAST) stateNext = FAIL;
                end
            READ_DATA:  if (byteDone && byteCnt == LAST_BYTE) stateNext = READ_CRC;
            READ_CRC:   if (byteDone && byteCnt == 9'd1) stateNext = TRAIL;
            TRAIL,
            FAIL:       if (byteDone) stateNext = DONE;
            DONE:       stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    // Counters restart on every state change so each phase counts its own bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sectorReg <= '0;
            byteCnt   <= '0;
            pollCnt   <= '0;
            pending   <= 1'b0;
            data      <= '0;
            dataValid <= 1'b0;
            isBusy    <= 1'b0;
            isFinish  <= 1'b0;
            error     <= 1'b0;
        end else begin
            dataValid <= 1'b0;
            if (byteDone)       pending <= 1'b0;
            else if (byteStart) pending <= 1'b1;
            if (rxStrobe && state == READ_DATA) begin
                data      <= rxByte;
                dataValid <= 1'b1;
            end
            if (state != stateNext) begin
                byteCnt <= '0;
                pollCnt <= '0;
            end else if (byteDone) begin
                byteCnt <= byteCnt + 9'd1;
                pollCnt <= pollCnt + 16'd1;
            end
            if (accept) begin
                sectorReg <= sector;
                isBusy    <= 1'b1;
                isFinish  <= 1'b0;
                error     <= 1'b0;
            end
            if (state == FAIL) error <= 1'b1;
            if (state == DONE) begin
                isBusy   <= 1'b0;
                isFinish <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_block_read.sv
// Self-checking bench: SPI card model, command/data scoreboards, table-driven transfers plus corner sequences.
module tb_sd_block_read;

    localparam int CLK_DIV = 2;
    localparam int R1_T    = 8;
    localparam int TOK_T   = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        initDone = 1'b0;
    logic        isStart = 1'b0;
    logic [31:0] sector = '0;
    logic        DO;
    logic        SCLK, DI, CS, dataValid, isBusy, isFinish, error;
    logic [7:0]  data;

    int checks = 0;
    int failures = 0;

    logic [7:0] outSh = 8'hFF;
    logic [7:0] inSh = 8'h00;
    int         inCnt = 0;
    int         csBytes = 0;
    int         lastCsBytes = 0;
    int         dvCount = 0;
    logic [7:0] respQ[$];
    logic [7:0] expCmdQ[$];
    logic [7:0] expDataQ[$];

    typedef struct {
        logic [31:0] sector;
        int          r1Delay;
        logic [7:0]  r1;
        int          tokPolls;
        logic [7:0]  token;
        logic        expError;
        int          expData;
        int          expBytes;
    } vecT;

    vecT vecs[5];

    sd_block_read #(.CLK_DIV(CLK_DIV), .R1_TIMEOUT(R1_T), .TOKEN_TIMEOUT(TOK_T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .initDone  (initDone),
        .isStart   (isStart),
        .sector    (sector),
        .DO        (DO),
        .SCLK      (SCLK),
        .DI        (DI),
        .CS        (CS),
        .data      (data),
        .dataValid (dataValid),
        .isBusy    (isBusy),
        .isFinish  (isFinish),
        .error     (error)
    );

    always #5 clk = ~clk;

    assign DO = outSh[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: condition not reached, expected it within budget", name);
    endtask

    // Card model: samples DI on rising SCLK, presents the next byte on the falling edge after a byte.
    always @(posedge CS) begin
        lastCsBytes = csBytes;
        csBytes     = 0;
        inCnt       = 0;
        outSh       = 8'hFF;
    end

    always @(posedge SCLK) begin
        if (!CS) begin
            inSh = {inSh[6:0], DI};
            inCnt++;
            if (inCnt == 8) begin
                inCnt = 0;
                if (csBytes < 6) begin
                    if (expCmdQ.size() > 0) begin
                        checkOutput($sformatf("cmdByte%0d", csBytes), 32'(inSh), 32'(expCmdQ.pop_front()));
                    end else begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL cmdUnexpected: got 0x%0h, expected no command", inSh);
                    end
                end
                csBytes++;
            end
        end
    end

    always @(negedge SCLK) begin
        if (!CS) begin
            if (inCnt == 0) begin
                if (csBytes >= 6 && respQ.size() > 0) outSh = respQ.pop_front();
                else                                  outSh = 8'hFF;
            end else begin
                outSh = {outSh[6:0], 1'b1};
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dataValid) begin
            dvCount++;
            if (expDataQ.size() > 0) begin
                checkOutput("dataByte", 32'(data), 32'(expDataQ.pop_front()));
            end else begin
                checks++;
                failures++;
                $display("[TB] FAIL dataUnexpected: got 0x%0h, expected no strobe", data);
            end
        end
    end

    task automatic loadCommand(input logic [31:0] s);
        expCmdQ.delete();
        expCmdQ.push_back(8'h51);
        expCmdQ.push_back(s[31:24]);
        expCmdQ.push_back(s[23:16]);
        expCmdQ.push_back(s[15:8]);
        expCmdQ.push_back(s[7:0]);
        expCmdQ.push_back(8'hFF);
    endtask

    task automatic buildResponse(input vecT v, input int mul, input int add);
        logic [7:0] b;
        respQ.delete();
        expDataQ.delete();
        for (int i = 0; i < v.r1Delay; i++) respQ.push_back(8'hFF);
        if (v.r1Delay < R1_T) begin
            respQ.push_back(v.r1);
            if (v.r1 == 8'h00) begin
                for (int i = 0; i < v.tokPolls; i++) respQ.push_back(8'hFF);
                if (v.tokPolls < TOK_T) begin
                    respQ.push_back(v.token);
                    if (v.token == 8'hFE) begin
                        for (int i = 0; i < 512; i++) begin
                            b = 8'(i * mul + add);
                            respQ.push_back(b);
                            expDataQ.push_back(b);
                        end
                        respQ.push_back(8'hA5);
                        respQ.push_back(8'h5A);
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] s);
        bit seen = 0;
        sector = s;
        @(negedge clk);
        isStart = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = isBusy;
        end
        isStart = 1'b0;
        if (!seen) failNow({tag, ".accept"});
        else begin
            checkOutput({tag, ".finishCleared"}, 32'(isFinish), 32'd0);
            checkOutput({tag, ".errorCleared"}, 32'(error), 32'd0);
        end
    endtask

    task automatic waitFinish(input string tag);
        bit seen = 0;
        for (int c = 0; c < 40000 && !seen; c++) begin
            @(negedge clk);
            seen = isFinish;
        end
        if (!seen) failNow({tag, ".finish"});
    endtask

    task automatic checkEnd(input string tag, input vecT v);
        checkOutput({tag, ".error"}, 32'(error), 32'(v.expError));
        checkOutput({tag, ".CS"}, 32'(CS), 32'd1);
        checkOutput({tag, ".isBusy"}, 32'(isBusy), 32'd0);
        checkOutput({tag, ".DI"}, 32'(DI), 32'd1);
        checkOutput({tag, ".SCLK"}, 32'(SCLK), 32'd0);
        checkOutput({tag, ".strobes"}, 32'(dvCount), 32'(v.expData));
        checkOutput({tag, ".csLowBytes"}, 32'(lastCsBytes), 32'(v.expBytes));
        checkOutput({tag, ".dataLeft"}, 32'(expDataQ.size()), 32'd0);
    endtask

    task automatic runRow(input string tag, input vecT v, input int mul, input int add);
        loadCommand(v.sector);
        buildResponse(v, mul, add);
        dvCount = 0;
        applyStimulus(tag, v.sector);
        waitFinish(tag);
        checkEnd(tag, v);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".SCLK"}, 32'(SCLK), 32'd0);
        checkOutput({tag, ".DI"}, 32'(DI), 32'd1);
        checkOutput({tag, ".CS"}, 32'(CS), 32'd1);
        checkOutput({tag, ".data"}, 32'(data), 32'd0);
        checkOutput({tag, ".dataValid"}, 32'(dataValid), 32'd0);
        checkOutput({tag, ".isBusy"}, 32'(isBusy), 32'd0);
        checkOutput({tag, ".isFinish"}, 32'(isFinish), 32'd0);
        checkOutput({tag, ".error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecT  v;
        bit   hit;
        // sector, r1Delay, r1, tokPolls, token, expError, expData, expBytes (command + response bytes with CS low)
        vecs[0] = '{32'h0000_0010, 2, 8'h00, 5,     8'hFE, 1'b0, 512, 6 + 3 + 6 + 514};
        vecs[1] = '{32'h0000_00A5, 0, 8'h04, 0,     8'hFE, 1'b1, 0,   6 + 1};
        vecs[2] = '{32'h0000_1234, 8, 8'h00, 0,     8'hFE, 1'b1, 0,   6 + R1_T};
        vecs[3] = '{32'h0000_0055, 1, 8'h00, 3,     8'h0B, 1'b1, 0,   6 + 2 + 4};
        vecs[4] = '{32'h0000_0077, 0, 8'h00, TOK_T, 8'hFE, 1'b1, 0,   6 + 1 + TOK_T};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rst_n = 1'b1;
        initDone = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) runRow($sformatf("row%0d", i), vecs[i], 1, 0);

        // Start requests while busy must not re-latch the sector; initDone dropping mid-transfer is harmless.
        v = '{32'h00AB_CDEF, 0, 8'h04, 0, 8'hFE, 1'b1, 0, 7};
        loadCommand(v.sector);
        buildResponse(v, 1, 0);
        dvCount = 0;
        applyStimulus("busy", v.sector);
        sector = 32'hFFFF_0000;
        isStart = 1'b1;
        repeat (20) @(negedge clk);
        isStart = 1'b0;
        initDone = 1'b0;
        waitFinish("busy");
        checkEnd("busy", v);
        isStart = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("noInit.isBusy", 32'(isBusy), 32'd0);
        checkOutput("noInit.CS", 32'(CS), 32'd1);
        checkOutput("noInit.isFinish", 32'(isFinish), 32'd1);
        checkOutput("noInit.error", 32'(error), 32'd1);
        isStart = 1'b0;
        initDone = 1'b1;
        @(negedge clk);

        // Reset in the middle of the data phase aborts at once; a fresh read then completes.
        v = '{32'h0000_0200, 1, 8'h00, 2, 8'hFE, 1'b0, 512, 6 + 2 + 3 + 514};
        loadCommand(v.sector);
        buildResponse(v, 1, 0);
        dvCount = 0;
        applyStimulus("rst", v.sector);
        hit = 0;
        for (int c = 0; c < 20000 && !hit; c++) begin
            @(negedge clk);
            hit = (dvCount >= 200);
        end
        if (!hit) failNow("rst.reachByte200");
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midReset");
        respQ.delete();
        expDataQ.delete();
        expCmdQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkResetOutputs("afterReset");

        v = '{32'h00C0_FFEE, 0, 8'h00, 1, 8'hFE, 1'b0, 512, 6 + 1 + 2 + 514};
        runRow("fresh", v, 7, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
